// File: rtl/led_ctrl_multi_if.sv
// Pin-side bundle of the LED controller: raw button and brightness in,
// current mode and LED drive out.
interface led_ctrl_multi_if #(
  parameter int N_LED    = 2,
  parameter int PWM_BITS = 8
);
  logic                PB_SW;
  logic [PWM_BITS-1:0] DUTY;
  logic [1:0]          MODE;
  logic [N_LED-1:0]    LED;

  modport master (output PB_SW, DUTY, input MODE, LED);
  modport slave  (input PB_SW, DUTY, output MODE, LED);
endinterface

// File: rtl/led_ctrl_multi.sv
// Multi-mode LED driver: debounced push-button steps OFF/BLINK/CHASE/DIM,
// with blink/chase tick timing and PWM dimming. All outputs registered.
module led_ctrl_multi #(
  parameter int N_LED      = 2,
  parameter int DEB_CYCLES = 500000,
  parameter int BLINK_DIV  = 12500000,
  parameter int PWM_BITS   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  led_ctrl_multi_if.slave  io
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(BLINK_DIV);
  localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0]    TICK_LAST  = TW'(BLINK_DIV - 1);
  localparam logic [N_LED-1:0] CHASE_INIT = N_LED'(1);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLINK = 2'd1,
    CHASE = 2'd2,
    DIM   = 2'd3
  } mode_t;

  mode_t               mode, mode_next;
  logic                sync1, sync2;
  logic                deb, deb_q;
  logic [DW-1:0]       deb_cnt;
  logic [TW-1:0]       tick_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase;
  logic [N_LED-1:0]    chase, chase_rot;
  logic [N_LED-1:0]    led, led_next;
  logic                press, tick;

  assign press = deb_q & ~deb;
  assign tick  = (tick_cnt == TICK_LAST);
  // Shift-based rotate also covers N_LED == 1, where the vector stays put.
  assign chase_rot = (chase << 1) | (chase >> (N_LED - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      deb     <= 1'b1;
      deb_q   <= 1'b1;
      deb_cnt <= '0;
    end else begin
      sync1 <= io.PB_SW;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) mode <= OFF;
    else       mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    if (press) begin
      unique case (mode)
        OFF:     mode_next = BLINK;
        BLINK:   mode_next = CHASE;
        CHASE:   mode_next = DIM;
        default: mode_next = OFF;
      endcase
    end
  end

  always_comb begin
    led_next = '0;
    unique case (mode)
      BLINK:   led_next = {N_LED{phase}};
      CHASE:   led_next = chase;
      DIM:     led_next = {N_LED{pwm_cnt < io.DUTY}};
      default: led_next = '0;
    endcase
  end

  // A press takes priority over a coincident tick: timing restarts cleanly.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tick_cnt <= '0;
      phase    <= 1'b1;
      chase    <= CHASE_INIT;
      pwm_cnt  <= '0;
      led      <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= led_next;
      if (press) begin
        tick_cnt <= '0;
        phase    <= 1'b1;
        chase    <= CHASE_INIT;
      end else if (tick) begin
        tick_cnt <= '0;
        phase    <= ~phase;
        chase    <= chase_rot;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign io.MODE = mode;
  assign io.LED  = led;

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Directed bench for led_ctrl_multi with N_LED=4, DEB_CYCLES=4, BLINK_DIV=8,
// PWM_BITS=4; expected values are hand-derived edge counts.
module tb_led_ctrl_multi;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  led_ctrl_multi_if #(.N_LED(4), .PWM_BITS(4)) bus ();

  led_ctrl_multi #(
    .N_LED(4),
    .DEB_CYCLES(4),
    .BLINK_DIV(8),
    .PWM_BITS(4)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .io(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge where MODE advances (edge 7 of the press).
  task automatic press_btn();
    bus.PB_SW = 1'b0;
    step(7);
  endtask

  task automatic release_btn();
    bus.PB_SW = 1'b1;
    step(8);
  endtask

  task automatic do_reset();
    bus.PB_SW = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic count_on(input int n, output int on, output int partial);
    on = 0;
    partial = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus.LED == 4'b1111) on++;
      else if (bus.LED != 4'b0000) partial++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int on, partial, waited;
    rst = 1'b1;
    bus.PB_SW = 1'b1;
    bus.DUTY = '0;
    step(2);
    check("reset_mode", bus.MODE, 2'd0);
    check("reset_led", bus.LED, 4'b0000);
    rst = 1'b0;

    // Mid-run asynchronous reset from BLINK
    press_btn();
    check("first_press_mode", bus.MODE, 2'd1);
    bus.PB_SW = 1'b1;
    step(3);
    check("blink_before_reset", bus.LED, 4'b1111);
    #3 rst = 1'b1;
    #1;
    check("async_reset_mode", bus.MODE, 2'd0);
    check("async_reset_led", bus.LED, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("idle_mode", bus.MODE, 2'd0);
      check("idle_led", bus.LED, 4'b0000);
    end

    // Debounce: short glitches rejected, held press accepted at edge 7
    for (int i = 0; i < 5; i++) begin
      bus.PB_SW = 1'b0;
      step(3);
      bus.PB_SW = 1'b1;
      step(3);
      check("glitch_mode", bus.MODE, 2'd0);
    end
    bus.PB_SW = 1'b0;
    step(6);
    check("deb_edge6_mode", bus.MODE, 2'd0);
    step(1);
    check("deb_edge7_mode", bus.MODE, 2'd1);
    step(1);
    check("deb_edge8_led", bus.LED, 4'b1111);
    step(12);
    bus.PB_SW = 1'b1;
    step(10);
    check("release_no_advance", bus.MODE, 2'd1);

    // Mode cycling
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press_btn();
      check("cycle_mode", bus.MODE, 32'((i + 1) % 4));
      release_btn();
    end
    step(2);
    check("off_led", bus.LED, 4'b0000);

    // BLINK: 8 cycles on, 8 off
    do_reset();
    press_btn();
    for (int k = 1; k <= 32; k++) begin
      step(1);
      check("blink_led", bus.LED, (((k - 1) / 8) % 2 == 0) ? 32'hF : 32'h0);
    end

    // CHASE: one-hot rotation every 8 cycles
    release_btn();
    press_btn();
    check("chase_mode", bus.MODE, 2'd2);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check("chase_led", bus.LED, 32'(1 << (((k - 1) / 8) % 4)));
    end

    // Press edge coincides with a BLINK tick at E+16
    do_reset();
    press_btn();
    bus.PB_SW = 1'b1;
    step(9);
    check("simul_blink_phase", bus.LED, 4'b0000);
    press_btn();
    check("simul_mode", bus.MODE, 2'd2);
    step(1);
    check("simul_led", bus.LED, 4'b0001);
    step(7);
    check("simul_hold", bus.LED, 4'b0001);
    step(1);
    check("simul_rotate", bus.LED, 4'b0010);

    // DIM
    bus.DUTY = 4'd0;
    release_btn();
    press_btn();
    check("dim_mode", bus.MODE, 2'd3);
    release_btn();
    count_on(32, on, partial);
    check("dim_duty0_on", 32'(on), 32'd0);
    check("dim_duty0_partial", 32'(partial), 32'd0);
    bus.DUTY = 4'd15;
    count_on(16, on, partial);
    check("dim_duty15_on", 32'(on), 32'd15);
    bus.DUTY = 4'd4;
    count_on(16, on, partial);
    check("dim_duty4_on", 32'(on), 32'd4);
    check("dim_duty4_partial", 32'(partial), 32'd0);

    // Align on the first lit cycle of a period, then raise duty mid-period
    waited = 0;
    while (bus.LED != 4'b0000 && waited < 40) begin step(1); waited++; end
    while (bus.LED != 4'b1111 && waited < 40) begin step(1); waited++; end
    check("dim_align_timeout", 32'(waited < 40), 32'd1);
    step(3);
    check("dim_last_on_old", bus.LED, 4'b1111);
    bus.DUTY = 4'd12;
    step(1);
    check("dim_duty_change", bus.LED, 4'b1111);
    step(7);
    check("dim_new_last_on", bus.LED, 4'b1111);
    step(1);
    check("dim_new_off", bus.LED, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_ctrl_multi.md
# led_ctrl_multi

Parametrised LED controller: N_LED outputs driven in one of four display modes selected by a debounced push-button. Sits between the board clock/reset tree and the LED pins as the next-generation LED driver. Adds synchronisation and debounce, blink/chase timing, and PWM dimming. All outputs are registered.

## Interface
- N_LED, 2, number of LED outputs (1..32)
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level change (>=2)
- BLINK_DIV, 12500000, clock cycles per blink/chase tick (>=2)
- PWM_BITS, 8, width of PWM counter and DUTY (1..16)

- CLK  in  1  system clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- PB_SW  in  1  raw push-button, active-low (0 = pressed), asynchronous to CLK
- DUTY  in  PWM_BITS  brightness for DIM mode; quasi-static, sampled every cycle
- MODE  out  2  current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 DIM
- LED  out  N_LED  LED drive, 1 = on

## Operation
- Reset values: MODE=0, LED=0, both synchroniser flops=1, debounced level=1 (released), debounce/tick/PWM counters=0, blink phase=1, chase vector=one-hot bit 0.
- Synchroniser: two flops on PB_SW, reset to 1.
- Debounce: counter width $clog2(DEB_CYCLES).
  - While sync==deb: counter=0.
  - While they differ: counter increments.
  - When counter==DEB_CYCLES-1 and they still differ: deb<=sync and counter<=0.
  - Any return to sync==deb before that point clears the counter. Glitches shorter than DEB_CYCLES are rejected.
- Press event: registered deb_q follows deb. press = deb_q & ~deb (falling edge only). Release never advances the mode.
- Mode FSM: OFF->BLINK->CHASE->DIM->OFF, one step per press; wraps 3->0.
- On every mode change: tick counter<=0, blink phase<=1, chase vector<=bit 0.
- Tick generator: counter 0..BLINK_DIV-1 wraps, width $clog2(BLINK_DIV). Tick is a one-cycle pulse on wrap. It runs in all modes; it is reset only on a mode change.
- PWM counter: free-running 0..2^PWM_BITS-1, wraps naturally.
- LED next-state by mode:
  - OFF: all 0.
  - BLINK: all = phase; phase toggles on tick.
  - CHASE: one-hot vector; rotates left on tick; bit N_LED-1 wraps to bit 0. With N_LED=1 the vector stays at bit 0.
  - DIM: all = (pwm_cnt < DUTY), unsigned compare. DUTY=0 gives always off; max DUTY gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- RESET asserted mid-operation: all state returns to reset values immediately (asynchronous). Operation resumes on the first CLK edge after deassertion. A button held through reset is seen as a press only after its debounce completes; this is intended.

## Timing
- Edge 1 is the first CLK edge that samples a new PB_SW level, held stable thereafter.
  - Edge 2: sync output changes.
  - Edge DEB_CYCLES+2: deb changes.
  - Edge DEB_CYCLES+3: MODE changes (press case).
  - Edge DEB_CYCLES+4: LED reflects the new mode.
- Tick pulse: first tick BLINK_DIV cycles after a mode change, then every BLINK_DIV cycles. LED updates one cycle after the tick.
- DIM: LED lags pwm_cnt/DUTY by one cycle. PWM period is exactly 2^PWM_BITS cycles.
- A press and a tick in the same cycle: the mode change wins, tick counter/phase/chase are reinitialised, and that tick is discarded.
- No combinational path from any input to any output.

## Test plan
Bench parameters for all scenarios: N_LED=4, DEB_CYCLES=4, BLINK_DIV=8, PWM_BITS=4.
- Reset/idle: assert RESET mid-run with PB_SW=1 -> MODE=0 and LED=4'b0000 immediately. Both remain 0 for 100 cycles after release.
- Debounce: PB_SW pulses low for 3 cycles, repeated 5 times -> MODE stays 0. PB_SW held low -> MODE=1 exactly at edge 7. Release after 20 cycles -> MODE stays 1.
- Mode cycling: 4 clean presses -> MODE 1,2,3,0, then LED=0000 in OFF.
- BLINK/CHASE: in BLINK, LED=1111 for 8 cycles, then 0000 for 8, repeating. In CHASE, LED sequence 0001,0010,0100,1000,0001 with 8 cycles per step.
- DIM: DUTY=0 -> LED always 0000. DUTY=4 -> 1111 for 4 of every 16 cycles. DUTY=15 -> 15 of 16. Change DUTY 4->12 mid-period -> new duty visible within one cycle.
- Simultaneous events: align the press edge with a tick in BLINK -> MODE=2, LED=0001, and the next rotation occurs 8 cycles later.
